// File: rtl/io_bus_arbiter_pkg.sv
// rtl/io_bus_arbiter_pkg.sv - shared types and constants for the two-master I/O bus arbiter
package io_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Down-counter width able to hold ACCESS_CYCLES-1, never narrower than one bit
    function automatic int cnt_width(input int access_cycles);
        return (access_cycles > 1) ? $clog2(access_cycles) : 1;
    endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// rtl/io_bus_arbiter_if.sv - requester handshakes and peripheral bus bundle for io_bus_arbiter
interface io_bus_arbiter_if
    import io_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic              io_rd;
    logic              io_wr;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_dout;
    logic [DATA_W-1:0] io_din;
    logic              busy;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_ack, m1_rdata,
        output io_rd, io_wr, io_addr, io_dout, busy,
        input  io_din
    );

    // Requesters and peripheral read mux
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_ack, m1_rdata,
        input  io_rd, io_wr, io_addr, io_dout, busy,
        output io_din
    );

endinterface

// File: rtl/io_bus_arbiter_rr_arb2.sv
// rtl/io_bus_arbiter_rr_arb2.sv - two-way round-robin winner select with last-served pointer
module rr_arb2
    import io_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       commit,
    input  logic       commit_idx,
    output logic [1:0] win,
    output logic       last
);

    // Pointer starts at master 1 so master 0 takes the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= M1;
        end else if (commit) begin
            last <= commit_idx;
        end
    end

    always_comb begin
        win = 2'b00;
        if (en) begin
            case (req)
                2'b01:   win = 2'b01;
                2'b10:   win = 2'b10;
                2'b11:   win = (last == M1) ? 2'b01 : 2'b10;
                default: win = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - round-robin two-master sequencer for the peripheral I/O bus
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W
)(
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    io_bus_arbiter_if.slave  bus
);

    localparam int             CNT_W    = cnt_width(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;

    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] io_addr_q, io_addr_d;
    logic [DATA_W-1:0] io_dout_q, io_dout_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic [1:0]        win;
    logic              last;
    logic              commit;

    rr_arb2 u_rr_arb2 (
        .clk        (sys_clk_i),
        .rst_n      (sys_rst_i),
        .req        ({bus.m1_req, bus.m0_req}),
        .en         (state_q == ST_IDLE),
        .commit     (commit),
        .commit_idx (owner_q),
        .win        (win),
        .last       (last)
    );

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            owner_q   <= M0;
            we_q      <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            io_addr_q <= '0;
            io_dout_q <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
            io_addr_q <= io_addr_d;
            io_dout_q <= io_dout_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // io_addr_q/io_dout_q double as the latched request fields, so they hold through ACK
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        we_d      = we_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rd_d      = rd_q;
        wr_d      = wr_q;
        busy_d    = busy_q;
        io_addr_d = io_addr_q;
        io_dout_d = io_dout_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        commit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win != 2'b00) begin
                    state_d   = ST_ACCESS;
                    cnt_d     = CNT_LOAD;
                    owner_d   = win[1] ? M1 : M0;
                    we_d      = win[1] ? bus.m1_we    : bus.m0_we;
                    io_addr_d = win[1] ? bus.m1_addr  : bus.m0_addr;
                    io_dout_d = win[1] ? bus.m1_wdata : bus.m0_wdata;
                    gnt0_d    = win[0];
                    gnt1_d    = win[1];
                    rd_d      = ~we_d;
                    wr_d      = we_d;
                    busy_d    = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    commit  = 1'b1;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack0_d  = (owner_q == M0);
                    ack1_d  = (owner_q == M1);
                    if (!we_q) begin
                        if (owner_q == M0) rdata0_d = bus.io_din;
                        else               rdata1_d = bus.io_din;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                state_d   = ST_IDLE;
                gnt0_d    = 1'b0;
                gnt1_d    = 1'b0;
                busy_d    = 1'b0;
                io_addr_d = '0;
                io_dout_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.m0_gnt   = gnt0_q;
    assign bus.m1_gnt   = gnt1_q;
    assign bus.m0_ack   = ack0_q;
    assign bus.m1_ack   = ack1_q;
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_rdata = rdata1_q;
    assign bus.io_rd    = rd_q;
    assign bus.io_wr    = wr_q;
    assign bus.io_addr  = io_addr_q;
    assign bus.io_dout  = io_dout_q;
    assign bus.busy     = busy_q;

    logic unused_last;
    assign unused_last = last;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - directed self-checking bench for io_bus_arbiter
module tb_io_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    io_bus_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
    io_bus_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

    io_bus_arbiter #(.ACCESS_CYCLES(2), .ADDR_W(16), .DATA_W(16)) dut_a (
        .sys_clk_i (clk),
        .sys_rst_i (rst_n),
        .bus       (bus_a)
    );

    io_bus_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(16), .DATA_W(16)) dut_b (
        .sys_clk_i (clk),
        .sys_rst_i (rst_n),
        .bus       (bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus_a.m0_req = 0; bus_a.m0_we = 0; bus_a.m0_addr = 0; bus_a.m0_wdata = 0;
        bus_a.m1_req = 0; bus_a.m1_we = 0; bus_a.m1_addr = 0; bus_a.m1_wdata = 0;
        bus_a.io_din = 0;
        bus_b.m0_req = 0; bus_b.m0_we = 0; bus_b.m0_addr = 0; bus_b.m0_wdata = 0;
        bus_b.m1_req = 0; bus_b.m1_we = 0; bus_b.m1_addr = 0; bus_b.m1_wdata = 0;
        bus_b.io_din = 0;

        // Reset state
        tick(); tick();
        chk("rst_gnt",   {bus_a.m0_gnt, bus_a.m1_gnt, bus_a.m0_ack, bus_a.m1_ack}, 0);
        chk("rst_io",    {bus_a.io_rd, bus_a.io_wr, bus_a.busy}, 0);
        chk("rst_addr",  bus_a.io_addr, 0);
        chk("rst_dout",  bus_a.io_dout, 0);
        chk("rst_rdata", {bus_a.m0_rdata, bus_a.m1_rdata}, 0);
        rst_n = 1;

        // Test 1: m0 read of 0x6902
        bus_a.m0_req = 1; bus_a.m0_we = 0; bus_a.m0_addr = 16'h6902; bus_a.io_din = 16'h1234;
        tick();
        chk("t1_gnt",   {bus_a.m0_gnt, bus_a.m1_gnt}, 2'b10);
        chk("t1_rd1",   {bus_a.io_rd, bus_a.io_wr}, 2'b10);
        chk("t1_addr",  bus_a.io_addr, 16'h6902);
        chk("t1_busy",  bus_a.busy, 1);
        tick();
        chk("t1_rd2",   {bus_a.io_rd, bus_a.io_wr, bus_a.m0_ack}, 3'b100);
        tick();
        chk("t1_ack",   {bus_a.io_rd, bus_a.io_wr, bus_a.m0_ack, bus_a.m0_gnt}, 4'b0011);
        chk("t1_rdata", bus_a.m0_rdata, 16'h1234);
        chk("t1_ackaddr", bus_a.io_addr, 16'h6902);
        bus_a.m0_req = 0;
        tick();
        chk("t1_idle",  {bus_a.m0_gnt, bus_a.m0_ack, bus_a.busy}, 0);
        chk("t1_idleaddr", bus_a.io_addr, 0);

        // Test 2: both write from reset
        rst_n = 0; tick(); rst_n = 1;
        bus_a.m0_req = 1; bus_a.m0_we = 1; bus_a.m0_addr = 16'h7010; bus_a.m0_wdata = 16'hAAAA;
        bus_a.m1_req = 1; bus_a.m1_we = 1; bus_a.m1_addr = 16'h7020; bus_a.m1_wdata = 16'h5555;
        tick();
        chk("t2_gnt0",  {bus_a.m0_gnt, bus_a.m1_gnt, bus_a.io_wr, bus_a.io_rd}, 4'b1010);
        chk("t2_dout0", bus_a.io_dout, 16'hAAAA);
        tick(); tick();
        chk("t2_ack0",  {bus_a.m0_ack, bus_a.m1_ack, bus_a.io_wr}, 3'b100);
        bus_a.m0_req = 0;
        tick();
        chk("t2_gap",   {bus_a.m0_gnt, bus_a.m1_gnt, bus_a.busy, bus_a.io_wr}, 0);
        tick();
        chk("t2_gnt1",  {bus_a.m0_gnt, bus_a.m1_gnt, bus_a.io_wr}, 3'b011);
        chk("t2_dout1", bus_a.io_dout, 16'h5555);
        chk("t2_addr1", bus_a.io_addr, 16'h7020);
        tick(); tick();
        chk("t2_ack1",  {bus_a.m0_ack, bus_a.m1_ack}, 2'b01);
        chk("t2_rdata", {bus_a.m0_rdata, bus_a.m1_rdata}, 0);
        bus_a.m1_req = 0;
        tick();

        // Test 3: continuous contention alternates, 4 cycles per transaction
        bus_a.m0_we = 0; bus_a.m1_we = 0; bus_a.io_din = 16'h0001;
        bus_a.m0_req = 1; bus_a.m1_req = 1;
        for (int t = 0; t < 6; t++) begin
            tick();
            chk($sformatf("t3_gnt%0d", t), {bus_a.m0_gnt, bus_a.m1_gnt}, (t % 2 == 0) ? 2'b10 : 2'b01);
            tick(); tick();
            chk($sformatf("t3_ack%0d", t), {bus_a.m0_ack, bus_a.m1_ack}, (t % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            chk($sformatf("t3_idle%0d", t), bus_a.busy, 0);
        end
        bus_a.m0_req = 0; bus_a.m1_req = 0;
        tick();
        chk("t3_done", bus_a.busy, 0);

        // Test 4: m1 drops req in second ACCESS cycle
        bus_a.m1_req = 1; bus_a.m1_we = 0; bus_a.m1_addr = 16'h7030; bus_a.io_din = 16'h0F0F;
        tick();
        chk("t4_gnt", bus_a.m1_gnt, 1);
        tick();
        bus_a.m1_req = 0;
        tick();
        chk("t4_ack",   bus_a.m1_ack, 1);
        chk("t4_rdata", bus_a.m1_rdata, 16'h0F0F);
        tick();
        chk("t4_noack", {bus_a.m1_ack, bus_a.busy}, 0);
        tick();
        chk("t4_nonew", {bus_a.m1_gnt, bus_a.busy, bus_a.io_rd}, 0);

        // Test 5: async reset during ACCESS; pointer left at m0 beforehand
        bus_a.m0_req = 1; bus_a.m0_we = 1; bus_a.m0_wdata = 16'h1111;
        tick(); tick(); tick();
        chk("t5_pre_ack", bus_a.m0_ack, 1);
        bus_a.m0_req = 0;
        tick();
        bus_a.m1_req = 1; bus_a.m1_we = 0;
        tick();
        chk("t5_acc", {bus_a.m1_gnt, bus_a.io_rd, bus_a.busy}, 3'b111);
        #2 rst_n = 0;
        #1;
        chk("t5_async", {bus_a.io_rd, bus_a.io_wr, bus_a.m0_gnt, bus_a.m1_gnt,
                         bus_a.m0_ack, bus_a.m1_ack, bus_a.busy}, 0);
        chk("t5_rdata", bus_a.m1_rdata, 0);
        bus_a.m0_req = 1;
        rst_n = 1;
        tick();
        chk("t5_tie", {bus_a.m0_gnt, bus_a.m1_gnt}, 2'b10);
        tick(); tick();
        chk("t5_ack", {bus_a.m0_ack, bus_a.m1_ack}, 2'b10);
        bus_a.m0_req = 0; bus_a.m1_req = 0;
        tick();

        // Test 6: ACCESS_CYCLES=1 instance
        bus_b.m0_req = 1; bus_b.m0_we = 0; bus_b.m0_addr = 16'h6000; bus_b.io_din = 16'h1111;
        tick();
        chk("t6_m0rd", bus_b.io_rd, 1);
        tick();
        chk("t6_m0ack", {bus_b.m0_ack, bus_b.io_rd}, 2'b10);
        chk("t6_m0rdata", bus_b.m0_rdata, 16'h1111);
        bus_b.m0_req = 0;
        tick();
        bus_b.m1_req = 1; bus_b.m1_we = 0; bus_b.m1_addr = 16'h7005; bus_b.io_din = 16'hBEEF;
        tick();
        chk("t6_rd",   {bus_b.io_rd, bus_b.io_wr, bus_b.m1_gnt}, 3'b101);
        chk("t6_addr", bus_b.io_addr, 16'h7005);
        tick();
        chk("t6_ack",  {bus_b.io_rd, bus_b.m1_ack, bus_b.m1_gnt}, 3'b011);
        chk("t6_rdata", bus_b.m1_rdata, 16'hBEEF);
        chk("t6_m0keep", bus_b.m0_rdata, 16'h1111);
        bus_b.m1_req = 0;
        tick();
        chk("t6_idle", {bus_b.m1_ack, bus_b.busy, bus_b.io_rd}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-master arbiter and sequencer for the SoC peripheral I/O bus (the 16-bit addr/din/dout/rd/wr bus whose upper address byte drives the chip-select decode for mult, div, uart and dp_ram). It lets the J1 CPU (master 0) share that bus with a second requester, master 1, such as a DMA or test engine. Arbitration is round-robin. The granted transaction is latched, rd/wr is driven for a fixed number of cycles, read data is captured, and completion is signalled with a one-cycle ack.

## Interface
Clock is `sys_clk_i`. Reset is `sys_rst_i`, which in this block is asynchronous and active-low: logic is reset while `sys_rst_i`=0.

Parameters:
- ACCESS_CYCLES, 2, number of cycles io_rd/io_wr is held per transaction; legal range ≥1.
- ADDR_W, 16, I/O address width.
- DATA_W, 16, I/O data width.

Ports:
- sys_clk_i  in  1  system clock.
- sys_rst_i  in  1  asynchronous, active-low reset.
- m0_req / m1_req  in  1  transaction request; held until the matching ack.
- m0_we / m1_we  in  1  1=write, 0=read.
- m0_addr / m1_addr  in  ADDR_W  target address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_gnt / m1_gnt  out  1  high while that master owns the bus.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  DATA_W  read result; valid in the ack cycle and held until that master's next read completes.
- io_rd  out  1  peripheral read strobe.
- io_wr  out  1  peripheral write strobe.
- io_addr  out  ADDR_W  peripheral address, driving the chip-select decode.
- io_dout  out  DATA_W  write data to peripherals.
- io_din  in  DATA_W  read data from the peripheral read mux.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - Sample m0_req and m1_req at the clock edge.
  - If either is high, select a winner, latch its we/addr/wdata into internal registers, set its gnt, load the cycle counter with ACCESS_CYCLES-1, and go to ACCESS.
- Round-robin rule:
  - One request high: that master wins.
  - Both requests high: the master not served last wins.
  - The last-served pointer resets to master 1, so master 0 wins the first tie.
- ACCESS:
  - io_addr and io_dout come from the latched registers.
  - io_wr = latched we; io_rd = !latched we.
  - Counter decrements each cycle. At count 0, capture io_din into the winner's rdata (reads only), update the pointer, and go to ACK.
- ACK: assert the winner's ack for exactly one cycle, with gnt still high, then return to IDLE.
- io_rd and io_wr are never high together, and never high outside ACCESS.
- io_addr and io_dout are 0 in IDLE. In ACK they hold their last ACCESS value.
- Deasserting req during ACCESS has no effect: the transaction completes and ack is still issued.
- A req still high in the IDLE cycle after ACK is a new transaction.
- Requester fields are latched in IDLE, so changes after the grant are ignored.
- Writes leave the rdata of both masters unchanged.
- Async reset mid-transaction: all outputs go to 0 immediately, the FSM goes to IDLE, the pointer goes to master 1, and the transaction is dropped with no ack.

## Timing
- Reset values: every output is 0, including all gnt, ack, rdata, io_* and busy.
- Request seen in IDLE at edge k:
  - gnt and ACCESS start at cycle k+1.
  - io_rd/io_wr are high for cycles k+1 … k+ACCESS_CYCLES.
  - ack is high in cycle k+ACCESS_CYCLES+1.
- Back-to-back throughput: one transaction per ACCESS_CYCLES+2 cycles, including one mandatory IDLE cycle between transactions.
- Read capture: io_din is sampled on the last ACCESS cycle's edge, so peripherals must present data within ACCESS_CYCLES cycles of io_rd rising.
- All outputs are registered. There is no combinational path from req to gnt.

## Structure
- Shared package io_arb_pkg holds:
  - the state encodings (IDLE, ACCESS, ACK);
  - master index constants M0=0, M1=1;
  - default ADDR_W and DATA_W.
- Sub-module rr_arb2: takes two requests, an enable and the pointer; produces a one-hot winner and updates the pointer. It is instantiated once.
- The counter width is derived from ACCESS_CYCLES.

## Test plan
1. m0 read only, addr 0x6902, ACCESS_CYCLES=2, io_din=0x1234 → io_rd high for 2 cycles with io_addr=0x6902; m0_ack one cycle later; m0_rdata=0x1234; io_wr stays 0.
2. m0 and m1 both request writes from reset, with wdata 0xAAAA and 0x5555 → m0 is served first, then m1, with an IDLE cycle between them; io_dout shows 0xAAAA then 0x5555; m0_rdata and m1_rdata stay 0.
3. Both masters hold req continuously for 6 transactions → grants alternate m0,m1,m0,m1,m0,m1; each transaction takes ACCESS_CYCLES+2 cycles.
4. m1 drops req in the second ACCESS cycle → transaction completes, m1_ack pulses once, and no second transaction starts.
5. sys_rst_i pulled low during ACCESS → io_rd, io_wr, gnt, ack and busy go to 0 without waiting for a clock; after release, the first tie is granted to m0.
6. ACCESS_CYCLES=1, m1 read of 0x7005 with io_din=0xBEEF → io_rd high for exactly 1 cycle; m1_ack follows next cycle with m1_rdata=0xBEEF; m0_rdata is unchanged.
